// File: rtl/mips_prog_loader_if.sv
// rtl/mips_prog_loader_if.sv - host byte link, memory write port and run control of the program loader
//
// Signals:
//   in_valid/in_data/in_ready : host byte stream, transfer = in_valid & in_ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write into core memory
//   cpu_run/cpu_halted        : core release and HLT report
//   load_err/busy             : frame status
// Modports:
//   master : loader side (drives ready, memory port, run control, status)
//   slave  : host/core side (drives stream bytes and the halt flag)
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              cpu_halted;
  logic              load_err;
  logic              busy;

  modport master (
    input  in_valid, in_data, cpu_halted,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy
  );

  modport slave (
    output in_valid, in_data, cpu_halted,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy
  );
endinterface

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - framed byte-stream program loader and run control for the MIPS32 core
//
// Frame: SYNC, N, 4*N big-endian data bytes, CSUM (XOR of N and all data bytes).
// Ports:
//   clk1  : clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mips_prog_loader_if.master (byte link, memory write port, run control, status)
module mips_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips_prog_loader_if.master  bus
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CSUM,
    S_RUN
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [7:0]        acc;
  logic [7:0]        words_left;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  // Only the three earlier bytes of a word need holding; the fourth arrives with the write.
  logic [23:0]       asm_word;

  logic              take;
  logic              word_done;

  // Ready depends on state alone so there is no in_valid -> in_ready path.
  assign bus.in_ready = (state != S_RUN);
  assign take         = bus.in_valid && bus.in_ready;
  assign bus.cpu_run  = (state == S_RUN);
  assign bus.busy     = (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (take && bus.in_data == SYNC) state_next = S_COUNT;
      end
      S_COUNT: begin
        if (take) state_next = (bus.in_data == 8'd0) ? S_CSUM : S_DATA;
      end
      S_DATA: begin
        if (take && byte_idx == 2'd3) begin
          word_done = 1'b1;
          if (words_left == 8'd1) state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (take) state_next = (bus.in_data == acc) ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (bus.cpu_halted) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= 8'd0;
      words_left    <= 8'd0;
      byte_idx      <= 2'd0;
      word_idx      <= '0;
      asm_word      <= 24'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'd0;
      bus.load_err  <= 1'b0;
    end else begin
      bus.mem_we <= word_done;
      case (state)
        S_IDLE: begin
          if (take && bus.in_data == SYNC) bus.load_err <= 1'b0;
        end
        S_COUNT: begin
          if (take) begin
            acc        <= bus.in_data;
            words_left <= bus.in_data;
            byte_idx   <= 2'd0;
            word_idx   <= '0;
          end
        end
        S_DATA: begin
          if (take) begin
            asm_word <= {asm_word[15:0], bus.in_data};
            acc      <= acc ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
          end
          if (word_done) begin
            // Address arithmetic wraps naturally at ADDR_W bits.
            bus.mem_addr  <= BASE + word_idx;
            bus.mem_wdata <= {asm_word, bus.in_data};
            word_idx      <= word_idx + 1'b1;
            words_left    <= words_left - 8'd1;
          end
        end
        S_CSUM: begin
          if (take && bus.in_data != acc) bus.load_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - self-checking bench for mips_prog_loader
module tb_mips_prog_loader;
  localparam int         ADDR_W = 10;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus();

  mips_prog_loader #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(0),
    .SYNC(SYNC)
  ) dut (
    .clk1(clk1),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Frame-position model: pos 0 waits for SYNC, 1 takes N, then data bytes, then CSUM.
  int                pos = 0;
  int                n_words = 0;
  logic [7:0]        frame[$];
  logic              m_run = 1'b0;
  logic              m_err = 1'b0;
  logic              m_we  = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [31:0]       m_wdata = '0;

  task automatic model_byte(input logic [7:0] b);
    int cnt;
    int k;
    logic [7:0] x;
    if (pos == 0) begin
      if (b == SYNC) begin
        pos   = 1;
        m_err = 1'b0;
      end
    end else if (pos == 1) begin
      n_words = int'(b);
      frame.delete();
      frame.push_back(b);
      pos = 2;
    end else if (pos < 2 + 4 * n_words) begin
      frame.push_back(b);
      pos++;
      cnt = pos - 2;
      if (cnt % 4 == 0) begin
        k       = cnt / 4 - 1;
        m_we    = 1'b1;
        m_addr  = ADDR_W'(k % (1 << ADDR_W));
        m_wdata = {frame[4*k+1], frame[4*k+2], frame[4*k+3], frame[4*k+4]};
      end
    end else begin
      x = 8'd0;
      foreach (frame[i]) x = x ^ frame[i];
      if (b == x) m_run = 1'b1;
      else        m_err = 1'b1;
      pos = 0;
    end
  endtask

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pos   = 0;
      frame.delete();
      m_run = 1'b0;
      m_err = 1'b0;
      m_we  = 1'b0;
    end else begin
      m_we = 1'b0;
      if (m_run) begin
        if (bus.cpu_halted) m_run = 1'b0;
      end else if (bus.in_valid) begin
        model_byte(bus.in_data);
      end
    end
  end

  logic [ADDR_W-1:0] addr_q[$];
  logic [31:0]       data_q[$];

  always @(negedge clk1) begin
    if (rst_n) begin
      check("in_ready", 32'(bus.in_ready), 32'(!m_run));
      check("mem_we", 32'(bus.mem_we), 32'(m_we));
      if (m_we) begin
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("cpu_run", 32'(bus.cpu_run), 32'(m_run));
      check("load_err", 32'(bus.load_err), 32'(m_err));
      check("busy", 32'(bus.busy), 32'(pos != 0));
      if (bus.mem_we) begin
        addr_q.push_back(bus.mem_addr);
        data_q.push_back(bus.mem_wdata);
      end
    end
  end

  logic [7:0] tx[$];

  task automatic send_tx(input int max_gap);
    foreach (tx[i]) begin
      int n;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk1);
      bus.in_valid = 1'b1;
      bus.in_data  = tx[i];
      n = 0;
      while (!bus.in_ready && n < 50) begin
        @(negedge clk1);
        n++;
      end
      if (n >= 50) begin
        timeout("byte_accept");
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic halt_core();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (!bus.cpu_run && n < 20) begin
      @(negedge clk1);
      n++;
    end
    if (n >= 20) begin
      timeout("wait_cpu_run");
      return;
    end
    bus.cpu_halted = 1'b1;
    @(negedge clk1);
    bus.cpu_halted = 1'b0;
    check("halt_cpu_run", 32'(bus.cpu_run), 32'd0);
    check("halt_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_scn1_writes(input string tag, input int first);
    check({tag, "_wr_count"}, 32'(addr_q.size()), 32'(first + 2));
    if (addr_q.size() == first + 2) begin
      check({tag, "_addr0"}, 32'(addr_q[first]), 32'd0);
      check({tag, "_data0"}, data_q[first], 32'h2801000A);
      check({tag, "_addr1"}, 32'(addr_q[first+1]), 32'd1);
      check({tag, "_data1"}, data_q[first+1], 32'h28020014);
    end
  endtask

  task automatic clear_log();
    addr_q.delete();
    data_q.delete();
  endtask

  initial begin
    logic [7:0] x;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'd0;
    bus.cpu_halted = 1'b0;

    // Reset values
    repeat (2) @(negedge clk1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk1);

    // Scenario 1: two-word image loads and starts the core
    clear_log();
    tx = '{8'hA5, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1F};
    send_tx(0);
    check("s1_cpu_run", 32'(bus.cpu_run), 32'd1);
    check("s1_load_err", 32'(bus.load_err), 32'd0);
    check_scn1_writes("s1", 0);

    // Scenario 4: bytes held off while running, halt returns to loading
    bus.in_valid = 1'b1;
    bus.in_data  = SYNC;
    repeat (3) @(negedge clk1);
    check("s4_in_ready", 32'(bus.in_ready), 32'd0);
    halt_core();
    check("s4_no_extra_wr", 32'(addr_q.size()), 32'd2);

    // Scenario 2: checksum error, then a good frame clears load_err on SYNC
    clear_log();
    tx = '{8'hA5, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1E};
    send_tx(0);
    @(negedge clk1);
    check("s2_load_err", 32'(bus.load_err), 32'd1);
    check("s2_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_scn1_writes("s2", 0);
    tx = '{8'hA5};
    send_tx(0);
    check("s2_err_clr", 32'(bus.load_err), 32'd0);
    tx = '{8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1F};
    send_tx(0);
    check("s2_cpu_run_ok", 32'(bus.cpu_run), 32'd1);
    halt_core();

    // Scenario 3: junk ahead of an empty image
    clear_log();
    tx = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00};
    send_tx(0);
    check("s3_cpu_run", 32'(bus.cpu_run), 32'd1);
    check("s3_no_wr", 32'(addr_q.size()), 32'd0);
    halt_core();

    // Scenario 5: random valid gaps give identical writes
    clear_log();
    tx = '{8'hA5, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1F};
    send_tx(3);
    check_scn1_writes("s5", 0);
    halt_core();

    // SYNC value inside the data is plain data; three-word frame with random bytes
    clear_log();
    tx = '{8'hA5, 8'h03};
    for (int i = 0; i < 12; i++) tx.push_back((i == 5) ? SYNC : 8'($urandom_range(0, 255)));
    x = 8'd0;
    foreach (tx[i]) if (i > 0) x = x ^ tx[i];
    tx.push_back(x);
    send_tx(2);
    check("s7_wr_count", 32'(addr_q.size()), 32'd3);
    check("s7_cpu_run", 32'(bus.cpu_run), 32'd1);
    halt_core();

    // Scenario 6: reset mid-frame keeps the completed word, then a fresh load
    clear_log();
    tx = '{8'hA5, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02};
    send_tx(0);
    @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("s6_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("s6_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("s6_rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("s6_rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check("s6_rst_load_err", 32'(bus.load_err), 32'd0);
    check("s6_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk1);
    #2 rst_n = 1'b1;
    @(negedge clk1);
    check("s6_partial_count", 32'(addr_q.size()), 32'd1);
    if (addr_q.size() == 1) begin
      check("s6_partial_addr", 32'(addr_q[0]), 32'd0);
      check("s6_partial_data", data_q[0], 32'h2801000A);
    end
    tx = '{8'hA5, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1F};
    send_tx(0);
    check("s6_cpu_run", 32'(bus.cpu_run), 32'd1);
    check_scn1_writes("s6", 1);
    halt_core();

    repeat (2) @(negedge clk1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
